// File: rtl/clk_divider_prog.sv
// -----------------------------------------------------------------------------
// clk_divider_prog
//   Runtime-programmable integer clock divider with 50% duty cycle for both
//   even and odd ratios. Ratio changes and enable start/stop are aligned to
//   output-period boundaries so the divided clock never shows runt pulses.
//
// Ports:
//   freq_src_clk  in   source clock (posedge logic, one negedge helper flop)
//   reset         in   asynchronous active-low reset
//   en            in   divider enable (level)
//   div_ratio     in   requested divide ratio N (CNT_W bits)
//   load          in   strobe: capture div_ratio into the shadow register
//   freq_new_clk  out  divided clock
//   period_tick   out  one-cycle pulse at the start of each output period
//   load_done     out  one-cycle pulse when the shadow ratio becomes active
//   pending       out  a loaded ratio is waiting for a period boundary
//   cfg_err       out  sticky: last loaded ratio was 0 or 1
// -----------------------------------------------------------------------------
module clk_divider_prog #(
  parameter int CNT_W     = 8,
  parameter int DEF_RATIO = 9
) (
  input  logic             freq_src_clk,
  input  logic             reset,
  input  logic             en,
  input  logic [CNT_W-1:0] div_ratio,
  input  logic             load,
  output logic             freq_new_clk,
  output logic             period_tick,
  output logic             load_done,
  output logic             pending,
  output logic             cfg_err
);

  localparam logic [CNT_W-1:0] DEF_R = CNT_W'(DEF_RATIO);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] ratio_q, ratio_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic             running_q, running_d;
  logic             hi_p_q, hi_p_d;
  logic             hi_n_q;
  logic             pending_q, pending_d;
  logic             cfg_err_q, cfg_err_d;
  logic             load_done_q, load_done_d;
  logic             tick_q, tick_d;

  logic             boundary_s;
  logic [CNT_W:0]   half_s;

  // Next-state logic: counter, boundary-aligned ratio swap, enable, load capture
  always_comb begin
    cnt_d       = cnt_q;
    ratio_d     = ratio_q;
    shadow_d    = shadow_q;
    running_d   = running_q;
    pending_d   = pending_q;
    cfg_err_d   = cfg_err_q;
    load_done_d = 1'b0;
    tick_d      = 1'b0;
    half_s      = '0;
    hi_p_d      = 1'b0;

    // While idle every posedge acts as a boundary, so a pending ratio or a
    // rising enable takes effect on the very next edge.
    boundary_s = (!running_q) || (cnt_q == (ratio_q - CNT_W'(1)));

    if (boundary_s) begin
      if (pending_q) begin
        ratio_d     = shadow_q;
        pending_d   = 1'b0;
        load_done_d = 1'b1;
      end else begin
        ratio_d     = ratio_q;
      end
      cnt_d = '0;
      if (en) begin
        running_d = 1'b1;
        tick_d    = 1'b1;
      end else begin
        running_d = 1'b0;
        tick_d    = 1'b0;
      end
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // High phase covers counts below ceil(N/2); uses the ratio that is
    // active for the count being produced, so a swap at the boundary
    // shapes the new period from its first edge.
    half_s = ({1'b0, ratio_d} + (CNT_W+1)'(1)) >> 1;
    if (running_d) begin
      hi_p_d = ({1'b0, cnt_d} < half_s);
    end else begin
      hi_p_d = 1'b0;
    end

    // A load in the boundary cycle lands after the swap above, so it waits
    // for the following boundary.
    if (load) begin
      if (div_ratio >= CNT_W'(2)) begin
        shadow_d  = div_ratio;
        pending_d = 1'b1;
        cfg_err_d = 1'b0;
      end else begin
        cfg_err_d = 1'b1;
      end
    end else begin
      cfg_err_d = cfg_err_q;
    end
  end

  // Posedge state registers
  always_ff @(posedge freq_src_clk or negedge reset) begin
    if (!reset) begin
      cnt_q       <= '0;
      ratio_q     <= DEF_R;
      shadow_q    <= DEF_R;
      running_q   <= 1'b0;
      hi_p_q      <= 1'b0;
      pending_q   <= 1'b0;
      cfg_err_q   <= 1'b0;
      load_done_q <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      ratio_q     <= ratio_d;
      shadow_q    <= shadow_d;
      running_q   <= running_d;
      hi_p_q      <= hi_p_d;
      pending_q   <= pending_d;
      cfg_err_q   <= cfg_err_d;
      load_done_q <= load_done_d;
      tick_q      <= tick_d;
    end
  end

  // Negedge helper: delays the high phase by half a source cycle for odd N
  always_ff @(negedge freq_src_clk or negedge reset) begin
    if (!reset) begin
      hi_n_q <= 1'b0;
    end else begin
      hi_n_q <= hi_p_q;
    end
  end

  // Both flops are low in the last cycle of every period, so switching the
  // odd/even selection at a boundary cannot glitch the output.
  assign freq_new_clk = ratio_q[0] ? (hi_p_q & hi_n_q) : hi_p_q;
  assign period_tick  = tick_q;
  assign load_done    = load_done_q;
  assign pending      = pending_q;
  assign cfg_err      = cfg_err_q;

endmodule

// File: doc/clk_divider_prog.md
Name: clk_divider_prog

Overview:
- Runtime-programmable integer clock divider producing a 50%-duty output clock for both even and odd ratios.
- Odd-ratio symmetry uses a negedge helper flop.
- Ratio changes are staged and applied only at an output-period boundary, so no runt or glitch pulses occur.
- Enable stop/start is also boundary-aligned.
- Sits in the clocking block and generates derived clocks and per-period tick strobes for downstream peripherals.

Parameters:
- CNT_W, 8: width of the divide-ratio field and the period counter.
- DEF_RATIO, 9: active ratio after reset; must be in 2..2^CNT_W-1.

Ports:
- freq_src_clk  input  1  source clock; all logic on posedge except the odd-ratio helper flop (negedge).
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- en  input  1  divider enable, level.
- div_ratio  input  CNT_W  requested divide ratio N.
- load  input  1  single-cycle strobe; captures div_ratio into the shadow register.
- freq_new_clk  output  1  divided clock.
- period_tick  output  1  one-source-cycle pulse at the start of each output period.
- load_done  output  1  one-cycle pulse when the shadow ratio becomes active.
- pending  output  1  a loaded ratio is waiting for a boundary.
- cfg_err  output  1  sticky; the last loaded ratio was 0 or 1.

Behaviour:
- Reset (reset=0, async):
  - cnt=0, running=0, hi_p=0, hi_n=0, active ratio=DEF_RATIO, shadow=DEF_RATIO.
  - pending=0, cfg_err=0, load_done=0, period_tick=0, freq_new_clk=0.
  - Deassertion takes effect at the next posedge.
- Counter: cnt counts 0..N-1 on posedge while running; wraps N-1 -> 0. The wrap edge is the period boundary.
- hi_p (posedge flop): hi_p = (new cnt < ceil(N/2)), where ceil(N/2) = (N+1)>>1, computed in CNT_W+1 bits.
- hi_n (negedge flop): copies hi_p on each negedge.
- Output:
  - Even N: freq_new_clk = hi_p. High N/2 cycles, low N/2 cycles.
  - Odd N=2k+1: freq_new_clk = hi_p & hi_n. Rises half a cycle after the boundary; high k+0.5 cycles, low k+0.5 cycles.
  - Output is the registered/AND of registered signals only.
- period_tick: 1 for the posedge cycle in which cnt becomes 0 while running, including the first cycle after start.
- Enable:
  - en rising while idle: at the next posedge, running=1, cnt=0, hi_p=1, period_tick=1.
  - en falling: the current period completes. At the boundary, running=0, cnt holds 0, hi_p=0; output stays low.
  - en re-asserted before the boundary: no stop; output continues uninterrupted.
- Ratio load:
  - load=1 with div_ratio>=2: shadow<=div_ratio, pending=1, and cfg_err is cleared.
  - load=1 with div_ratio<2: shadow unchanged, cfg_err=1, pending unchanged.
  - While running: shadow -> active at the next boundary; load_done=1 in that cycle; pending=0.
  - While idle: applied at the next posedge with load_done=1.
  - A second load before the boundary overwrites shadow; only one load_done is issued.
  - load coincident with the boundary cycle: the new value waits for the following boundary.
- Boundary conditions:
  - N=2 gives freq_src_clk/2.
  - N=2^CNT_W-1: counter must not overflow.
  - Ratio change and en fall at the same boundary: the new ratio becomes active, load_done pulses, and the divider stops.
  - Reset mid-period: output drops to 0 immediately (async); the ratio returns to DEF_RATIO.

Test Plan:
- Reset release, en=1, default N=9 -> freq_new_clk period 9 source cycles, high 4.5/low 4.5 (measured at 10 ns source: 45 ns/45 ns); period_tick every 9 cycles.
- load div_ratio=4 mid-period -> pending=1; the current N=9 period completes intact; load_done pulses at the boundary; then 2-high/2-low.
- load 7 then 3 within one period -> single load_done; active N=3 (1.5/1.5 cycles); 7 never appears.
- load div_ratio=1 -> cfg_err=1; ratio unchanged at 9; a later load of 6 clears cfg_err and gives 3/3.
- en deasserted at cnt=2 with N=8 -> output finishes its 4-low phase, then stays 0; re-enable -> period_tick plus rising output on the first posedge.
- reset asserted asynchronously while freq_new_clk=1 -> output 0 without a clock edge; after release, N=9 again; N=255 run checks no wrap before cnt=254.
